uart_tx_tick: RTL and testbench

- Serial transmitter driven by the baud-rate strobe from the clock divider, which runs in pulse mode with one-clock-wide ticks.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as a UART frame: start bit, data bits, optional parity bit, then stop bit(s).
- Each serial bit lasts exactly one tick period.
- Sits directly downstream of the divider and feeds the board TX pin.

---
 rtl/uart_tx_tick.sv | 126 ++++++++++++
 tb/tb_uart_tx_tick.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_tick.sv
// UART frame transmitter paced by a one-clock baud strobe from the clock divider.
// Frames are start bit, LSB-first data, optional parity and stop bit(s), with every output registered.
module uart_tx_tick #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned STOP_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_BITS-1:0]  shift;
  logic                  par_bit;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [STOP_CNT_W-1:0] stop_cnt;
  logic                  par_c;

  // Parity of the word being accepted; odd mode inverts the plain XOR.
  assign par_c = (PARITY == 1) ? ~(^data) : (^data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // Ticks are ignored here, so a tick in the accept cycle never starts the frame.
        IDLE: begin
          if (valid && ready) begin
            shift    <= data;
            par_bit  <= par_c;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= BIT_CNT_W'(1);
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt < BIT_CNT_W'(DATA_BITS)) begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (PARITY != 0) begin
              tx    <= par_bit;
              state <= PAR;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= STOP_CNT_W'(1);
              state    <= STOP;
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= STOP_CNT_W'(1);
            state    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt < STOP_CNT_W'(STOP_BITS)) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              done  <= 1'b1;
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: four parameterisations (8N1, 8O1, 8E1, 8N2) sharing clock, tick and reset.
// Expectations come from frame bit lists built per word and a tick-sampling UART receiver model.
module tb_uart_tx_tick;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] data;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  logic       rx_s[$];
  int         gaps[$];
  int         ferr;
  int         dones;
  int         accepts;

  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data(data), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data(data), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data(data), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_n2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data(data), .valid(valid_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_of(input int idx);
    return (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
  endfunction

  function automatic int stop_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accepts one word, ticks every per clk and checks tx/done/ready/busy every cycle.
  task automatic frame_check(input string name, input int idx, input logic [7:0] w,
                             input int per, input bit tick_acc, input bit poke);
    logic fb[$];
    logic pb;
    logic e_tx;
    int   n;
    int   k;
    int   c;
    bit   tk;
    fb.push_back(1'b0);
    for (int b = 0; b < 8; b++) fb.push_back(w[b]);
    if (par_of(idx) != 0) begin
      pb = 1'($countones(w) % 2);
      if (par_of(idx) == 1) pb = ~pb;
      fb.push_back(pb);
    end
    for (int s = 0; s < stop_of(idx); s++) fb.push_back(1'b1);
    n = fb.size() + 1;

    data = w;
    valid_v[idx] = 1'b1;
    tick = tick_acc;
    @(posedge clk); #1;
    valid_v[idx] = 1'b0;
    tick = 1'b0;
    chk1({name, "_acc_ready"}, ready_v[idx], 1'b0);
    chk1({name, "_acc_busy"}, busy_v[idx], 1'b1);
    chk1({name, "_acc_tx"}, tx_v[idx], 1'b1);
    chk1({name, "_acc_done"}, done_v[idx], 1'b0);

    k = 0;
    c = 0;
    while (k < n + 2) begin
      c++;
      tk = (c % per == 0);
      tick = tk;
      if (poke && k == 3 && (c % per) == 1) begin
        data = 8'hFF;
        valid_v[idx] = 1'b1;
      end else begin
        valid_v[idx] = 1'b0;
      end
      @(posedge clk); #1;
      if (tk) k++;
      e_tx = (k >= 1 && k <= fb.size()) ? fb[k-1] : 1'b1;
      chk1({name, "_tx"}, tx_v[idx], e_tx);
      chk1({name, "_done"}, done_v[idx], tk && (k == n));
      chk1({name, "_ready"}, ready_v[idx], k >= n);
      chk1({name, "_busy"}, busy_v[idx], k < n);
    end
    tick = 1'b0;
    valid_v[idx] = 1'b0;
  endtask

  // Streams src_q with valid held high; records tx at every tick as a receiver would.
  task automatic run_rx(input int idx, input int pmin, input int pmax);
    int cd;
    int budget;
    int cyc;
    bit tk;
    rx_s.delete();
    dones = 0;
    accepts = 0;
    budget = (src_q.size() + 2) * 20 * pmax;
    cd = int'($urandom_range(pmax, pmin));
    cyc = 0;
    while (!(src_q.size() == 0 && dones == accepts) && cyc < budget) begin
      cyc++;
      cd--;
      tk = (cd == 0);
      if (tk) cd = int'($urandom_range(pmax, pmin));
      tick = tk;
      if (src_q.size() > 0) begin
        valid_v[idx] = 1'b1;
        data = src_q[0];
      end else begin
        valid_v[idx] = 1'b0;
      end
      if (tk) rx_s.push_back(tx_v[idx]);
      if (valid_v[idx] && ready_v[idx]) begin
        void'(src_q.pop_front());
        accepts++;
      end
      @(posedge clk); #1;
      if (done_v[idx]) dones++;
    end
    tick = 1'b0;
    valid_v[idx] = 1'b0;
    chk1("rx_budget", cyc < budget, 1'b1);
  endtask

  // Receiver model for 8 data bits, no parity: decodes words, framing errors and idle gaps.
  task automatic decode(input int stops);
    int i;
    int last;
    int prev_last;
    int sz;
    logic [7:0] w;
    dec_q.delete();
    gaps.delete();
    ferr = 0;
    i = 0;
    prev_last = -1;
    sz = rx_s.size();
    while (i < sz) begin
      if (rx_s[i] !== 1'b0) begin
        i++;
      end else if (i + 8 + stops > sz - 1) begin
        ferr++;
        i = sz;
      end else begin
        for (int b = 0; b < 8; b++) w[b] = rx_s[i+1+b];
        last = i + 8;
        for (int q = 1; q <= stops; q++) if (rx_s[last+q] !== 1'b1) ferr++;
        if (prev_last >= 0) gaps.push_back(i - prev_last - 1);
        prev_last = last;
        dec_q.push_back(w);
        i = last + 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    tick = 1'b0;
    data = 8'h00;
    valid_v = 4'b0000;
    #3 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 4; d++) begin
      chk1("rst_tx", tx_v[d], 1'b1);
      chk1("rst_ready", ready_v[d], 1'b1);
      chk1("rst_busy", busy_v[d], 1'b0);
      chk1("rst_done", done_v[d], 1'b0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    frame_check("n1_a5", 0, 8'hA5, 4, 1'b0, 1'b0);
    frame_check("even_a5", 2, 8'hA5, 4, 1'b0, 1'b0);
    frame_check("odd_a5", 1, 8'hA5, 4, 1'b0, 1'b0);
    frame_check("even_07", 2, 8'h07, 4, 1'b0, 1'b0);
    frame_check("odd_07", 1, 8'h07, 5, 1'b0, 1'b0);
    frame_check("n2_c6", 3, 8'hC6, 3, 1'b0, 1'b0);
    frame_check("busy_poke", 0, 8'h3C, 4, 1'b0, 1'b1);
    frame_check("tick_acc", 0, 8'hC3, 3, 1'b1, 1'b0);
    frame_check("tick_acc_e", 2, 8'h5E, 4, 1'b1, 1'b0);

    // Asynchronous reset while shifting data bit 1 of 0x3C.
    data = 8'h3C;
    valid_v[0] = 1'b1;
    tick = 1'b0;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick = (t % 4 == 0);
      @(posedge clk); #1;
    end
    tick = 1'b0;
    chk1("pre_rst_tx", tx_v[0], 1'b0);
    chk1("pre_rst_ready", ready_v[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_tx", tx_v[0], 1'b1);
    chk1("mid_rst_ready", ready_v[0], 1'b1);
    chk1("mid_rst_busy", busy_v[0], 1'b0);
    chk1("mid_rst_done", done_v[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_tx", tx_v[0], 1'b1);
    frame_check("rst_81", 0, 8'h81, 4, 1'b0, 1'b0);

    // Back-to-back with two stop bits.
    src_q.delete();
    src_q.push_back(8'h55);
    src_q.push_back(8'hAA);
    run_rx(3, 4, 4);
    decode(2);
    chki("b2b_count", dec_q.size(), 2);
    chki("b2b_word0", (dec_q.size() > 0) ? int'(dec_q[0]) : -1, 32'h55);
    chki("b2b_word1", (dec_q.size() > 1) ? int'(dec_q[1]) : -1, 32'hAA);
    chki("b2b_gap", (gaps.size() > 0) ? gaps[0] : -1, 3);
    chki("b2b_ferr", ferr, 0);
    chki("b2b_done", dones, 2);

    // Random words with tick period jittering between 3 and 7 clk.
    src_q.delete();
    exp_q.delete();
    for (int j = 0; j < 1000; j++) begin
      src_q.push_back(8'($urandom));
      exp_q.push_back(src_q[j]);
    end
    run_rx(0, 3, 7);
    decode(1);
    chki("jit_count", dec_q.size(), 1000);
    for (int j = 0; j < 1000; j++) begin
      chki("jit_word", (j < dec_q.size()) ? int'(dec_q[j]) : -1, int'(exp_q[j]));
    end
    chki("jit_ferr", ferr, 0);
    chki("jit_accepts", accepts, 1000);
    chki("jit_done", dones, accepts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
